// File: rtl/pong_renderer_if.sv
// rtl/pong_renderer_if.sv - game-state inputs and video outputs of the pong renderer
interface pong_renderer_if #(
    parameter int COORD_WIDTH = 10
);
    logic [COORD_WIDTH-1:0] ball_x;
    logic [COORD_WIDTH-1:0] ball_y;
    logic [COORD_WIDTH-1:0] paddle1_y;
    logic [COORD_WIDTH-1:0] paddle2_y;
    logic                   hsync;
    logic                   vsync;
    logic                   video_active;
    logic [2:0]             rgb;
    logic                   frame_tick;

    modport master (
        output ball_x, ball_y, paddle1_y, paddle2_y,
        input  hsync, vsync, video_active, rgb, frame_tick
    );

    modport slave (
        input  ball_x, ball_y, paddle1_y, paddle2_y,
        output hsync, vsync, video_active, rgb, frame_tick
    );
endinterface

// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - VGA timing, per-frame state snapshot and ball/paddle/centre-line drawing
module pong_renderer #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int COORD_WIDTH   = 10,
    parameter int BALL_RADIUS   = 4,
    parameter int PADDLE_HALF_W = 4,
    parameter int PADDLE_HALF_H = 40,
    parameter int P1_X          = 50,
    parameter int P2_X          = 590
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_en,
    pong_renderer_if.slave  vid
);
    localparam int CW = COORD_WIDTH;
    localparam int SW = COORD_WIDTH + 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] H_MID    = CW'(H_ACTIVE / 2);
    localparam logic [CW-1:0] V_MID    = CW'(V_ACTIVE / 2);
    localparam logic [CW-1:0] P1X      = CW'(P1_X);
    localparam logic [CW-1:0] P2X      = CW'(P2_X);

    localparam logic signed [SW-1:0] BALL_R = SW'(BALL_RADIUS);
    localparam logic signed [SW-1:0] PAD_W  = SW'(PADDLE_HALF_W);
    localparam logic signed [SW-1:0] PAD_H  = SW'(PADDLE_HALF_H);

    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] sh_bx, sh_by, sh_p1y, sh_p2y;
    logic          ball_hit, pad1_hit, pad2_hit, line_hit, in_active;
    logic [2:0]    pix_rgb;

    // One extra bit keeps the difference signed, so shapes near 0 never wrap to the far edge.
    function automatic logic near(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                  input logic signed [SW-1:0] r);
        logic signed [SW-1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d <= r) && (d >= -r);
    endfunction

    always_comb begin
        in_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        ball_hit  = near(h_cnt, sh_bx, BALL_R) && near(v_cnt, sh_by, BALL_R);
        pad1_hit  = near(h_cnt, P1X, PAD_W) && near(v_cnt, sh_p1y, PAD_H);
        pad2_hit  = near(h_cnt, P2X, PAD_W) && near(v_cnt, sh_p2y, PAD_H);
        line_hit  = (h_cnt == H_MID) && !v_cnt[3];
        pix_rgb   = 3'b000;
        if (in_active) begin
            if (ball_hit)      pix_rgb = 3'b111;
            else if (pad1_hit) pix_rgb = 3'b100;
            else if (pad2_hit) pix_rgb = 3'b001;
            else if (line_hit) pix_rgb = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            sh_bx  <= H_MID;
            sh_by  <= V_MID;
            sh_p1y <= V_MID;
            sh_p2y <= V_MID;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                // Latch game state on the last pixel so the whole next frame sees one consistent snapshot.
                if (v_cnt == V_LAST) begin
                    sh_bx  <= vid.ball_x;
                    sh_by  <= vid.ball_y;
                    sh_p1y <= vid.paddle1_y;
                    sh_p2y <= vid.paddle2_y;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vid.hsync        <= 1'b1;
            vid.vsync        <= 1'b1;
            vid.video_active <= 1'b0;
            vid.rgb          <= 3'b000;
            vid.frame_tick   <= 1'b0;
        end else begin
            vid.frame_tick <= pix_en && (h_cnt == '0) && (v_cnt == V_ACT);
            if (pix_en) begin
                vid.hsync        <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
                vid.vsync        <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
                vid.video_active <= in_active;
                vid.rgb          <= pix_rgb;
            end
        end
    end
endmodule

// File: tb/tb_pong_renderer.sv
// tb/tb_pong_renderer.sv - randomized check of pong_renderer against a frame-position reference model
module tb_pong_renderer;
    localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
    localparam int CW = 10;
    localparam int BR = 2, PW = 1, PH = 4, P1X = 5, P2X = 34;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    pong_renderer_if #(.COORD_WIDTH(CW)) vif ();

    pong_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COORD_WIDTH(CW), .BALL_RADIUS(BR), .PADDLE_HALF_W(PW),
        .PADDLE_HALF_H(PH), .P1_X(P1X), .P2_X(P2X)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .vid(vif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ticks    = 0;

    int mpos;
    int sbx, sby, sp1, sp2;
    logic [6:0] mout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t pos=%0d)", tag, got, exp, $time, mpos);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Expected {hsync, vsync, video_active, rgb, frame_tick} for the pixel at (x, y).
    function automatic logic [6:0] pixel_model(input int x, input int y);
        logic [2:0] c;
        logic hs, vs, act;
        hs  = !(x >= HA + HFP && x < HA + HFP + HS);
        vs  = !(y >= VA + VFP && y < VA + VFP + VS);
        act = (x < HA) && (y < VA);
        c = 3'b000;
        if (act) begin
            if (iabs(x - sbx) <= BR && iabs(y - sby) <= BR)      c = 3'b111;
            else if (iabs(x - P1X) <= PW && iabs(y - sp1) <= PH) c = 3'b100;
            else if (iabs(x - P2X) <= PW && iabs(y - sp2) <= PH) c = 3'b001;
            else if (x == HA / 2 && ((y / 8) % 2) == 0)          c = 3'b010;
        end
        return {hs, vs, act, c, (x == 0 && y == VA)};
    endfunction

    function automatic logic [6:0] observed();
        return {vif.hsync, vif.vsync, vif.video_active, vif.rgb, vif.frame_tick};
    endfunction

    task automatic model_reset();
        mpos = 0;
        sbx = HA / 2; sby = VA / 2; sp1 = VA / 2; sp2 = VA / 2;
        mout = 7'b1100000;
    endtask

    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) begin
            mout = pixel_model(mpos % HT, mpos / HT);
            if (mpos == FT - 1) begin
                sbx = int'(vif.ball_x); sby = int'(vif.ball_y);
                sp1 = int'(vif.paddle1_y); sp2 = int'(vif.paddle2_y);
                mpos = 0;
            end else begin
                mpos++;
            end
        end else begin
            mout[0] = 1'b0;
        end
        if (vif.frame_tick) ticks++;
        check("pixel_outputs", 32'(observed()), 32'(mout));
    endtask

    function automatic logic [CW-1:0] rand_coord();
        if ($urandom_range(0, 9) == 0) return CW'($urandom_range(1018, 1023));
        return CW'($urandom_range(0, HA + 4));
    endfunction

    task automatic rand_inputs();
        vif.ball_x    = rand_coord();
        vif.ball_y    = rand_coord();
        vif.paddle1_y = rand_coord();
        vif.paddle2_y = rand_coord();
    endtask

    task automatic set_inputs(input int bx, input int by, input int p1, input int p2);
        vif.ball_x = CW'(bx); vif.ball_y = CW'(by);
        vif.paddle1_y = CW'(p1); vif.paddle2_y = CW'(p2);
    endtask

    initial begin
        rst = 1'b0;
        pix_en = 1'b0;
        set_inputs(0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(observed()), 32'(7'b1100000));
        rst = 1'b1;

        // Continuous pixel enable with game state changing mid-frame.
        ticks = 0;
        for (int i = 0; i < 3 * FT; i++) begin
            if (i % 300 == 150) rand_inputs();
            step(1'b1);
        end
        check("tick_count_continuous", 32'(ticks), 32'd3);

        // Shapes clipped at the top-left corner; bottom paddle.
        set_inputs(2, 2, 0, VA - 1);
        for (int i = 0; i < 2 * FT; i++) step(1'b1);

        // Ball overlapping paddle 1.
        set_inputs(P1X + 2, VA / 2, VA / 2, 3);
        for (int i = 0; i < 2 * FT; i++) step(1'b1);

        // Pixel enable one clock in four.
        ticks = 0;
        for (int i = 0; i < 8 * FT; i++) begin
            if (i % 1000 == 500) rand_inputs();
            step(i % 4 == 0);
        end
        check("tick_count_quarter_rate", 32'(ticks), 32'd2);

        // Asynchronous reset in the middle of the visible area.
        for (int i = 0; i < 4 * FT && mpos != HT * (VA / 2) + 7; i++) step(i % 4 == 0);
        check("reached_reset_point", 32'(mpos), 32'(HT * (VA / 2) + 7));
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'(observed()), 32'(7'b1100000));
        model_reset();
        @(posedge clk);
        #1;
        check("held_in_reset", 32'(observed()), 32'(7'b1100000));
        rst = 1'b1;

        ticks = 0;
        set_inputs(HA - 1, VA - 1, 1020, 1);
        for (int i = 0; i < 2 * FT; i++) step(1'b1);
        check("tick_count_after_reset", 32'(ticks), 32'd2);

        for (int i = 0; i < 2 * FT; i++) begin
            if (i % 400 == 100) rand_inputs();
            step(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pong_renderer.md
Name: pong_renderer

Overview:
Display-side consumer of the game state produced by the pong top level.
- Generates 640x480 VGA-style timing and samples ball_x/ball_y and both paddle positions once per frame into shadow registers.
- Draws ball, paddles and a dashed centre line as 3-bit RGB.
- Returns a one-cycle frame_tick to the game logic, so ball/paddle/score updates happen during vertical blanking.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
COORD_WIDTH, 10, width of all coordinate inputs and counters
BALL_RADIUS, 4, ball half-size (square ball)
PADDLE_HALF_W, 4, paddle half-width
PADDLE_HALF_H, 40, paddle half-height
P1_X, 50, paddle 1 centre x
P2_X, 590, paddle 2 centre x

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pix_en  in  1  pixel-rate clock enable; all state advances only on clk edges with pix_en=1
ball_x  in  COORD_WIDTH  ball centre x from game logic
ball_y  in  COORD_WIDTH  ball centre y
paddle1_y  in  COORD_WIDTH  paddle 1 centre y
paddle2_y  in  COORD_WIDTH  paddle 2 centre y
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
video_active  out  1  high while the output pixel is visible
rgb  out  3  pixel colour {r,g,b}
frame_tick  out  1  one-clk pulse at start of vertical blanking

Behaviour:
- One clock domain. rst is asynchronous and active-low: asserting it forces state at once. Release is sampled on clk.
- Reset values:
  - h_cnt=0, v_cnt=0
  - hsync=1, vsync=1
  - video_active=0, rgb=0, frame_tick=0
  - shadow ball=(320,240), shadow paddles=240
- Counters: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
  - On pix_en, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1.
- Output pipeline: all outputs are registered and update only on pix_en cycles.
  - They are computed from the current (pre-increment) counters, so outputs lag the counters by exactly one pixel.
  - hsync, vsync, video_active and rgb stay mutually aligned.
- hsync=0 iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- vsync=0 iff v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- video_active=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Snapshot: on a pix_en cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, all four coordinate inputs are latched into shadow registers. Drawing uses only shadow values, so input changes mid-frame have no visible effect until the next frame.
- frame_tick: 1 for exactly one clk, on the pix_en cycle where h_cnt=0 and v_cnt=V_ACTIVE. It is 0 otherwise, including stall cycles.
- Hit tests use COORD_WIDTH+1-bit signed differences, with no wrap-around near 0 or near the max coordinate.
  - Ball hit: |x-bx|<=BALL_RADIUS and |y-by|<=BALL_RADIUS.
  - Paddle n hit: |x-Pn_X|<=PADDLE_HALF_W and |y-pny|<=PADDLE_HALF_H.
  - Centre line: x==H_ACTIVE/2 and y[3]==0.
- Colour priority (highest first), inside the active region only:
  - ball 3'b111
  - paddle1 3'b100
  - paddle2 3'b001
  - centre line 3'b010
  - background 3'b000
- Outside the active region, rgb=0.
- Out-of-range coordinates (e.g. ball_x>=640) are not an error. Only the in-range part of the shape is drawn.
- pix_en=0: all registers hold, including outputs. frame_tick is forced 0.
- Reset mid-frame: immediate return to reset values. After release, the frame restarts at (0,0) with reset shadow values until the first snapshot.

Test Plan:
1. pix_en=1 continuously after reset: line period 800 clk; hsync low for 96 clk starting at pixel 656; frame period 420000 clk; vsync low for lines 490-491; frame_tick once per 420000 clk.
2. Shadow ball at (100,200), paddles at 240: row 200 gives rgb=111 for x 96..104 and 000 at x 95 and 105. Row 240 gives 100 for x 46..54 and 001 for x 586..594. Row 0 gives 010 at x 320.
3. ball_x changed from 100 to 300 at line 100: rest of frame still draws at 100; next frame draws at 300, after the end-of-frame snapshot.
4. Ball (2,2), paddle1_y=0: ball drawn at x 0..6, y 0..6 with no wrap at x 1020+. Paddle1 drawn on rows 0..40 only.
5. Ball overlapping paddle1 (ball_x=52, ball_y=240): overlap pixels are 111 (ball priority).
6. pix_en toggling 1-in-4: all timing scales by 4, outputs held between enables, frame_tick single clk. Assert rst at line 300: outputs immediately reset; counters restart at 0.
